// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial transmit scheduler.
package serial_tx_pkg;

    localparam int N_REQ  = 3;
    localparam int ID_W   = 2;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 2**LEN_W - 1;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ID,
        LEN,
        DATA,
        STOP
    } tx_state_e;

    // Requester slot k positions after p, wrapping over the three requesters.
    function automatic logic [ID_W-1:0] rr_slot(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        while (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Line level for a given state; sel is the remaining-bit index of the current field.
    function automatic logic frame_bit(input tx_state_e st,
                                       input logic [1:0] sel,
                                       input logic [ID_W-1:0] id,
                                       input logic [LEN_W-1:0] len,
                                       input logic d0);
        logic b;
        case (st)
            START:   b = START_LEVEL;
            ID:      b = id[sel[0]];
            LEN:     b = len[sel];
            DATA:    b = d0;
            default: b = IDLE_LEVEL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational round-robin pick among three requesters, starting at the pointer.
module rr_arbiter3
    import serial_tx_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_valid
);

    // Walk from lowest to highest priority so the highest-priority hit wins last.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = |i_req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[rr_slot(i_ptr, k)]) begin
                o_idx = rr_slot(i_ptr, k);
                o_gnt = N_REQ'(1) << rr_slot(i_ptr, k);
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin frame scheduler driving one shared serial line.
//
// state | meaning
// IDLE  | line high, sampling requests
// START | start bit (low)
// ID    | 2-bit port id, MSB first
// LEN   | 4-bit length, MSB first
// DATA  | payload, LSB first, len cycles
// STOP  | stop bit (high), done pulse
module serial_tx_scheduler
    import serial_tx_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*LEN_W-1:0]    len_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic                      ser_out,
    output logic                      busy
);

    tx_state_e          r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ID_W-1:0]    r_id, w_id_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]   r_done, w_done_nxt;
    logic               r_ser, r_busy;

    logic [N_REQ-1:0]   w_arb_gnt;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_valid;

    rr_arbiter3 u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign ser_out = r_ser;
    assign busy    = r_busy;

    // Next-state, field counter and frame latch; data shifts right so bit 0 is always the next payload bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_id_nxt    = r_id;
        w_len_nxt   = r_len;
        w_data_nxt  = r_data;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = START;
                    w_id_nxt    = w_arb_idx;
                    w_len_nxt   = len_i[int'(w_arb_idx)*LEN_W +: LEN_W];
                    w_data_nxt  = data_i[int'(w_arb_idx)*DATA_W +: DATA_W];
                    w_ptr_nxt   = rr_slot(w_arb_idx, 1);
                    w_gnt_nxt   = w_arb_gnt;
                end
            end
            START: begin
                w_state_nxt = ID;
                w_cnt_nxt   = LEN_W'(ID_W - 1);
            end
            ID: begin
                if (r_cnt == '0) begin
                    w_state_nxt = LEN;
                    w_cnt_nxt   = LEN_W'(LEN_W - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - LEN_W'(1);
                end
            end
            LEN: begin
                if (r_cnt == '0) begin
                    if (r_len == '0) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = r_len - LEN_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                end
            end
            DATA: begin
                w_data_nxt = r_data >> 1;
                if (r_cnt == '0) begin
                    w_state_nxt = STOP;
                end else begin
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                end
            end
            STOP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_state_nxt == STOP) begin
            w_done_nxt = N_REQ'(1) << r_id;
        end
    end

    // State and datapath registers; the line bit is computed from next-state values so every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_ser   <= IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
            r_len   <= w_len_nxt;
            r_data  <= w_data_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_ser   <= frame_bit(w_state_nxt, w_cnt_nxt[1:0], w_id_nxt, w_len_nxt, w_data_nxt[0]);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Self-checking bench for serial_tx_scheduler: directed table, directed corner sequences, random traffic vs a frame-queue model.
module tb_serial_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0;
    logic [11:0] len_i = '0;
    logic [44:0] data_i = '0;
    logic [2:0]  gnt, done;
    logic        ser_out, busy;

    int checks = 0;
    int failures = 0;

    serial_tx_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len_i   (len_i),
        .data_i  (data_i),
        .gnt     (gnt),
        .done    (done),
        .ser_out (ser_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ser;
        logic       busy;
        logic [2:0] gnt;
        logic [2:0] done;
    } obs_t;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [3:0]  len0;
        logic [14:0] data0;
        obs_t        e;
    } vec_t;

    // Reference: each grant expands into the full list of per-cycle line observations.
    obs_t mq[$];
    obs_t exp_o;
    int   mptr = 0;

    function automatic obs_t mk(logic s, logic b, logic [2:0] g, logic [2:0] d);
        return {s, b, g, d};
    endfunction

    task automatic model_edge();
        int w;
        logic [3:0]  l;
        logic [14:0] d;
        logic [1:0]  idv;
        logic [2:0]  oh;
        if (!rst) begin
            mq.delete();
            mptr = 0;
            exp_o = mk(1'b1, 1'b0, 3'b000, 3'b000);
        end else begin
            if (mq.size() == 0 && req != 3'b000) begin
                w = -1;
                for (int k = 0; k < 3; k++) begin
                    if (w < 0 && req[(mptr + k) % 3]) w = (mptr + k) % 3;
                end
                mptr = (w + 1) % 3;
                l   = len_i[w*4 +: 4];
                d   = data_i[w*15 +: 15];
                idv = 2'(w);
                oh  = 3'(1 << w);
                mq.push_back(mk(1'b0, 1'b1, oh, 3'b000));
                mq.push_back(mk(idv[1], 1'b1, 3'b000, 3'b000));
                mq.push_back(mk(idv[0], 1'b1, 3'b000, 3'b000));
                for (int b = 3; b >= 0; b--) mq.push_back(mk(l[b], 1'b1, 3'b000, 3'b000));
                for (int b = 0; b < int'(l); b++) mq.push_back(mk(d[b], 1'b1, 3'b000, 3'b000));
                mq.push_back(mk(1'b1, 1'b1, 3'b000, oh));
                mq.push_back(mk(1'b1, 1'b0, 3'b000, 3'b000));
            end
            if (mq.size() != 0) exp_o = mq.pop_front();
            else                exp_o = mk(1'b1, 1'b0, 3'b000, 3'b000);
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d required %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic cmp_obs(string tag, obs_t e);
        chk({tag, " ser_out"}, 32'(ser_out), 32'(e.ser));
        chk({tag, " busy"},    32'(busy),    32'(e.busy));
        chk({tag, " gnt"},     32'(gnt),     32'(e.gnt));
        chk({tag, " done"},    32'(done),    32'(e.done));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        cmp_obs(tag, exp_o);
    endtask

    task automatic do_reset(int n);
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < n; i++) step("reset");
        rst = 1'b1;
    endtask

    vec_t       tbl[17];
    logic [2:0] exp_ord[4];
    logic [2:0] got_ord[4];
    logic       pend[3];

    initial begin
        int ng, nb, nd, nd0;

        // rst, req, len0, data0, {ser, busy, gnt, done}
        tbl[0]  = '{1'b0, 3'b000, 4'd5, 15'b10110, mk(1, 0, 3'b000, 3'b000)};
        tbl[1]  = '{1'b0, 3'b000, 4'd5, 15'b10110, mk(1, 0, 3'b000, 3'b000)};
        tbl[2]  = '{1'b0, 3'b000, 4'd5, 15'b10110, mk(1, 0, 3'b000, 3'b000)};
        tbl[3]  = '{1'b1, 3'b001, 4'd5, 15'b10110, mk(0, 1, 3'b001, 3'b000)};
        tbl[4]  = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(0, 1, 3'b000, 3'b000)};
        tbl[5]  = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(0, 1, 3'b000, 3'b000)};
        tbl[6]  = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(0, 1, 3'b000, 3'b000)};
        tbl[7]  = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(1, 1, 3'b000, 3'b000)};
        tbl[8]  = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(0, 1, 3'b000, 3'b000)};
        tbl[9]  = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(1, 1, 3'b000, 3'b000)};
        tbl[10] = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(0, 1, 3'b000, 3'b000)};
        tbl[11] = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(1, 1, 3'b000, 3'b000)};
        tbl[12] = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(1, 1, 3'b000, 3'b000)};
        tbl[13] = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(0, 1, 3'b000, 3'b000)};
        tbl[14] = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(1, 1, 3'b000, 3'b000)};
        tbl[15] = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(1, 1, 3'b000, 3'b001)};
        tbl[16] = '{1'b1, 3'b000, 4'd5, 15'b10110, mk(1, 0, 3'b000, 3'b000)};

        for (int i = 0; i < 17; i++) begin
            rst           = tbl[i].rst;
            req           = tbl[i].req;
            len_i[3:0]    = tbl[i].len0;
            data_i[14:0]  = tbl[i].data0;
            @(posedge clk);
            model_edge();
            #1;
            cmp_obs($sformatf("tbl[%0d]", i), tbl[i].e);
        end
        for (int i = 0; i < 4; i++) step("tbl idle");

        // All three requesting with len=1: grants 0,1,2,0 from a fresh pointer.
        do_reset(2);
        len_i  = {4'd1, 4'd1, 4'd1};
        data_i = {15'h0001, 15'h0000, 15'h0001};
        req    = 3'b111;
        exp_ord = '{3'b001, 3'b010, 3'b100, 3'b001};
        got_ord = '{3'b000, 3'b000, 3'b000, 3'b000};
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            step("rr");
            if (gnt != 3'b000) begin
                got_ord[ng] = gnt;
                ng++;
            end
        end
        req = '0;
        for (int k = 0; k < 4; k++) chk($sformatf("rr order[%0d]", k), 32'(got_ord[k]), 32'(exp_ord[k]));
        for (int i = 0; i < 12; i++) step("rr tail");

        // Zero-length frame on requester 2: 8 busy cycles, one done pulse.
        do_reset(2);
        len_i[11:8] = 4'd0;
        data_i[44:30] = 15'h5A5A;
        req = 3'b100;
        nb = 0; nd = 0;
        for (int i = 0; i < 13; i++) begin
            step("len0");
            req = '0;
            if (busy === 1'b1) nb++;
            if (done === 3'b100) nd++;
        end
        chk("len0 busy cycles", 32'(nb), 32'd8);
        chk("len0 done pulses", 32'(nd), 32'd1);

        // Maximum length on requester 1: 23 busy cycles.
        do_reset(2);
        len_i[7:4] = 4'd15;
        data_i[29:15] = 15'h7FFF;
        req = 3'b010;
        nb = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            step("len15");
            req = '0;
            if (busy === 1'b1) nb++;
            if (done === 3'b010) nd++;
        end
        chk("len15 busy cycles", 32'(nb), 32'd23);
        chk("len15 done pulses", 32'(nd), 32'd1);

        // Reset in the middle of a len=8 payload, then requester 1 alone.
        do_reset(2);
        len_i[3:0] = 4'd8;
        data_i[14:0] = 15'h00AA;
        req = 3'b001;
        step("midrst");
        req = '0;
        for (int i = 0; i < 9; i++) step("midrst frame");
        rst = 1'b0;
        step("midrst edge");
        chk("midrst ser_out", 32'(ser_out), 32'd1);
        chk("midrst done", 32'(done), 32'd0);
        rst = 1'b1;
        len_i[7:4] = 4'd2;
        data_i[29:15] = 15'h0002;
        req = 3'b010;
        nd = 0; nd0 = 0;
        for (int i = 0; i < 20; i++) begin
            step("midrst next");
            req = '0;
            if (done === 3'b010) nd++;
            if (done === 3'b001) nd0++;
        end
        chk("midrst req1 done", 32'(nd), 32'd1);
        chk("midrst req0 done", 32'(nd0), 32'd0);

        // Random traffic: requests held with stable fields until granted, rare resets.
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_o.gnt[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    len_i[i*4 +: 4]   = 4'($urandom_range(0, 15));
                    data_i[i*15 +: 15] = 15'($urandom);
                end
                req[i] = pend[i];
            end
            rst = ($urandom_range(0, 299) != 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
